// File: rtl/lsu_ctrl.sv
// Load/store unit between the ALU and data memory: one outstanding req/gnt/rvalid
// access, store byte-lane steering, load extension, and a core stall while busy.
module lsu_ctrl #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic             req_write,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] wdata,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] rdata_out,
    output logic             fault,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [3:0]       mem_be,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_gnt,
    input  logic             mem_rvalid,
    input  logic [WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    function automatic logic is_legal(input logic wr, input logic [2:0] f3, input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        case (f3)
            3'b000:  ok = 1'b1;
            3'b001:  ok = ~off[0];
            3'b010:  ok = (off == 2'b00);
            3'b100:  ok = ~wr;
            3'b101:  ok = ~wr & ~off[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] steer_be(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        be = 4'b1111;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [WIDTH-1:0] steer_wdata(input logic [2:0] f3, input logic [WIDTH-1:0] w);
        logic [WIDTH-1:0] d;
        d = w;
        case (f3[1:0])
            2'b00:   d = {4{w[7:0]}};
            2'b01:   d = {2{w[15:0]}};
            default: d = w;
        endcase
        return d;
    endfunction

    function automatic logic [WIDTH-1:0] extract(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [WIDTH-1:0] word);
        logic [7:0]       b;
        logic [15:0]      h;
        logic [WIDTH-1:0] r;
        b = 8'h00;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = word[7:0];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        r = word;
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'h000000, b};
            3'b101:  r = {16'h0000, h};
            default: r = word;
        endcase
        return r;
    endfunction

    state_t           state_r;
    state_t           next_state_s;
    logic             legal_s;
    logic             fault_set_s;
    logic             capture_s;
    logic             latch_s;
    logic             wr_r;
    logic [2:0]       f3_r;
    logic [1:0]       off_r;
    logic [15:0]      cnt_r;
    logic             done_r;
    logic             fault_r;
    logic             mem_req_r;
    logic             mem_we_r;
    logic [WIDTH-1:0] mem_addr_r;
    logic [3:0]       mem_be_r;
    logic [WIDTH-1:0] mem_wdata_r;
    logic [WIDTH-1:0] rdata_r;

    assign legal_s = is_legal(req_write, funct3, addr[1:0]);

    // Next-state decode; illegal or misaligned requests skip memory and fault directly.
    always_comb begin
        next_state_s = state_r;
        fault_set_s  = 1'b0;
        capture_s    = 1'b0;
        latch_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    if (legal_s) begin
                        next_state_s = REQ;
                        latch_s      = 1'b1;
                    end else begin
                        next_state_s = DONE;
                        fault_set_s  = 1'b1;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    if (wr_r) begin
                        next_state_s = DONE;
                    end else if (mem_rvalid) begin
                        capture_s    = 1'b1;
                        next_state_s = DONE;
                    end else begin
                        next_state_s = WAIT;
                    end
                end else begin
                    next_state_s = REQ;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    capture_s    = 1'b1;
                    next_state_s = DONE;
                end else if (cnt_r >= TO_LAST) begin
                    fault_set_s  = 1'b1;
                    next_state_s = DONE;
                end else begin
                    next_state_s = WAIT;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State, request latches, memory-side outputs and load result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            wr_r        <= 1'b0;
            f3_r        <= 3'b000;
            off_r       <= 2'b00;
            cnt_r       <= 16'd0;
            done_r      <= 1'b0;
            fault_r     <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_be_r    <= 4'b0000;
            mem_wdata_r <= '0;
            rdata_r     <= '0;
        end else begin
            state_r   <= next_state_s;
            done_r    <= (next_state_s == DONE);
            fault_r   <= fault_set_s;
            mem_req_r <= (next_state_s == REQ);
            cnt_r     <= (state_r == WAIT && next_state_s == WAIT) ? cnt_r + 16'd1 : 16'd0;
            if (state_r == IDLE && req_valid) begin
                wr_r  <= req_write;
                f3_r  <= funct3;
                off_r <= addr[1:0];
            end
            if (latch_s) begin
                mem_we_r    <= req_write;
                mem_addr_r  <= {addr[WIDTH-1:2], 2'b00};
                mem_be_r    <= req_write ? steer_be(funct3, addr[1:0]) : 4'b1111;
                mem_wdata_r <= req_write ? steer_wdata(funct3, wdata) : '0;
            end
            if (capture_s) begin
                rdata_r <= extract(f3_r, off_r, mem_rdata);
            end
        end
    end

    // Core advances in the DONE cycle, so the stall drops there.
    assign stall     = req_valid & (state_r != DONE);
    assign done      = done_r;
    assign fault     = fault_r;
    assign rdata_out = rdata_r;
    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_be    = mem_be_r;
    assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: stores, loads with extension, faults, timeout
// and mid-transaction reset, with hand-computed expectations.
module tb_lsu_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata_out;
    logic        fault;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    lsu_ctrl #(.WIDTH(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
        .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall), .done(done),
        .rdata_out(rdata_out), .fault(fault), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; funct3 = 3'b000;
        addr = 32'h0; wdata = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        #2;
        if ({stall, done, fault, mem_req, mem_we} !== 5'b00000) begin errors++; $display("FAIL reset_ctrl: got %b exp 00000", {stall, done, fault, mem_req, mem_we}); end checks++;
        if ({mem_addr, mem_be, mem_wdata, rdata_out} !== 100'h0) begin errors++; $display("FAIL reset_data: addr %h be %b wdata %h rdata %h exp 0", mem_addr, mem_be, mem_wdata, rdata_out); end checks++;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_store_sw();
        req_valid = 1'b1; req_write = 1'b1; funct3 = 3'b010; addr = 32'h0000_0104;
        wdata = 32'hDEAD_BEEF; mem_gnt = 1'b1;
        #1;
        if (stall !== 1'b1) begin errors++; $display("FAIL sw_stall0: got %b exp 1", stall); end checks++;
        tick();
        if (mem_req !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL sw_req: req %b we %b exp 1 1", mem_req, mem_we); end checks++;
        if (mem_addr !== 32'h0000_0104) begin errors++; $display("FAIL sw_addr: got %h exp 00000104", mem_addr); end checks++;
        if (mem_be !== 4'b1111) begin errors++; $display("FAIL sw_be: got %b exp 1111", mem_be); end checks++;
        if (mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_wdata: got %h exp deadbeef", mem_wdata); end checks++;
        if (stall !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL sw_stall1: stall %b done %b exp 1 0", stall, done); end checks++;
        tick();
        if (done !== 1'b1 || fault !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL sw_done: done %b fault %b stall %b exp 1 0 0", done, fault, stall); end checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL sw_req_drop: got %b exp 0", mem_req); end checks++;
        req_valid = 1'b0;
        tick();
        if (done !== 1'b0) begin errors++; $display("FAIL sw_done_pulse: got %b exp 0", done); end checks++;
        mem_gnt = 1'b0;
    endtask

    task automatic test_store_sb();
        req_valid = 1'b1; req_write = 1'b1; funct3 = 3'b000; addr = 32'h0000_0203;
        wdata = 32'h0000_00A5; mem_gnt = 1'b0;
        tick();
        if (mem_addr !== 32'h0000_0200) begin errors++; $display("FAIL sb_addr: got %h exp 00000200", mem_addr); end checks++;
        if (mem_be !== 4'b1000) begin errors++; $display("FAIL sb_be: got %b exp 1000", mem_be); end checks++;
        if (mem_wdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL sb_wdata: got %h exp a5a5a5a5", mem_wdata); end checks++;
        tick();
        if (mem_req !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL sb_hold: req %b done %b exp 1 0", mem_req, done); end checks++;
        mem_gnt = 1'b1;
        tick();
        if (done !== 1'b1) begin errors++; $display("FAIL sb_done: got %b exp 1", done); end checks++;
        req_valid = 1'b0; mem_gnt = 1'b0;
        tick();
    endtask

    task automatic do_load_wait(input string name, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] exp);
        req_valid = 1'b1; req_write = 1'b0; funct3 = f3; addr = a; mem_gnt = 1'b1;
        mem_rvalid = 1'b0; mem_rdata = 32'h1234_80FF;
        tick();
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_be !== 4'b1111) begin errors++; $display("FAIL %s_req: req %b we %b be %b exp 1 0 1111", name, mem_req, mem_we, mem_be); end checks++;
        tick();
        tick();
        if (mem_req !== 1'b0 || done !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL %s_wait: req %b done %b stall %b exp 0 0 1", name, mem_req, done, stall); end checks++;
        tick();
        mem_rvalid = 1'b1;
        tick();
        if (done !== 1'b1 || fault !== 1'b0) begin errors++; $display("FAIL %s_done: done %b fault %b exp 1 0", name, done, fault); end checks++;
        if (rdata_out !== exp) begin errors++; $display("FAIL %s_rdata: got %h exp %h", name, rdata_out, exp); end checks++;
        mem_rvalid = 1'b0; req_valid = 1'b0; mem_gnt = 1'b0;
        tick();
    endtask

    task automatic test_load_ext();
        do_load_wait("lb",  3'b000, 32'h0000_0301, 32'hFFFF_FF80);
        do_load_wait("lbu", 3'b100, 32'h0000_0301, 32'h0000_0080);
        do_load_wait("lhu", 3'b101, 32'h0000_0302, 32'h0000_1234);
    endtask

    task automatic test_back_to_back();
        req_valid = 1'b1; req_write = 1'b0; funct3 = 3'b001; addr = 32'h0000_0040;
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1234_80FF;
        tick();
        tick();
        if (done !== 1'b1 || rdata_out !== 32'hFFFF_80FF) begin errors++; $display("FAIL lh_fast: done %b rdata %h exp 1 ffff80ff", done, rdata_out); end checks++;
        funct3 = 3'b010; addr = 32'h0000_0044; mem_rdata = 32'hCAFE_0001;
        tick();
        if (done !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL b2b_idle: done %b stall %b exp 0 1", done, stall); end checks++;
        tick();
        tick();
        if (done !== 1'b1 || rdata_out !== 32'hCAFE_0001) begin errors++; $display("FAIL b2b_lw: done %b rdata %h exp 1 cafe0001", done, rdata_out); end checks++;
        req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        tick();
    endtask

    task automatic do_fault(input string name, input logic wr, input logic [2:0] f3, input logic [31:0] a);
        req_valid = 1'b1; req_write = wr; funct3 = f3; addr = a; mem_gnt = 1'b1; mem_rvalid = 1'b1;
        tick();
        if (done !== 1'b1 || fault !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL %s: done %b fault %b req %b exp 1 1 0", name, done, fault, mem_req); end checks++;
        req_valid = 1'b0; mem_rvalid = 1'b0; mem_gnt = 1'b0;
        tick();
        if (done !== 1'b0 || fault !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL %s_after: done %b fault %b req %b exp 0 0 0", name, done, fault, mem_req); end checks++;
    endtask

    task automatic test_faults();
        do_fault("lw_misalign", 1'b0, 3'b010, 32'h0000_0102);
        do_fault("ld_f3_011",   1'b0, 3'b011, 32'h0000_0100);
        do_fault("sh_misalign", 1'b1, 3'b001, 32'h0000_0101);
        do_fault("st_f3_100",   1'b1, 3'b100, 32'h0000_0100);
    endtask

    task automatic test_timeout();
        logic [31:0] prev;
        prev = rdata_out;
        req_valid = 1'b1; req_write = 1'b0; funct3 = 3'b010; addr = 32'h0000_0010;
        mem_gnt = 1'b1; mem_rvalid = 1'b0; mem_rdata = 32'h5555_AAAA;
        tick();
        tick();
        for (int i = 1; i <= 3; i++) begin
            tick();
            if (done !== 1'b0) begin errors++; $display("FAIL to_early%0d: done %b exp 0", i, done); end checks++;
        end
        tick();
        if (done !== 1'b1 || fault !== 1'b1) begin errors++; $display("FAIL to_fault: done %b fault %b exp 1 1", done, fault); end checks++;
        if (rdata_out !== prev) begin errors++; $display("FAIL to_rdata: got %h exp %h", rdata_out, prev); end checks++;
        req_valid = 1'b0; mem_gnt = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_write = 1'b0; funct3 = 3'b010; addr = 32'h0000_0FF0;
        mem_gnt = 1'b1; mem_rvalid = 1'b0; mem_rdata = 32'h0BAD_F00D;
        tick();
        tick();
        tick();
        rst_n = 1'b0; req_valid = 1'b0; mem_gnt = 1'b0;
        #1;
        if ({stall, done, fault, mem_req, mem_we} !== 5'b00000) begin errors++; $display("FAIL rst_mid_ctrl: got %b exp 00000", {stall, done, fault, mem_req, mem_we}); end checks++;
        if ({mem_addr, mem_be, mem_wdata, rdata_out} !== 100'h0) begin errors++; $display("FAIL rst_mid_data: addr %h be %b wdata %h rdata %h exp 0", mem_addr, mem_be, mem_wdata, rdata_out); end checks++;
        tick();
        rst_n = 1'b1;
        tick();
        mem_rvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done !== 1'b0 || rdata_out !== 32'h0) begin errors++; $display("FAIL rst_late%0d: done %b rdata %h exp 0 0", i, done, rdata_out); end checks++;
        end
        mem_rvalid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_store_sw();
        test_store_sb();
        test_load_ext();
        test_back_to_back();
        test_faults();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
